// File: rtl/jtdsp16_pseq_pkg.sv
// Shared encodings for the jtdsp16 program sequencer.
package jtdsp16_pseq_pkg;

    // Source of the next program address
    typedef enum logic [1:0] {
        SEL_SEQ      = 2'd0,
        SEL_JMP      = 2'd1,
        SEL_RET      = 2'd2,
        SEL_LOOPBACK = 2'd3
    } pc_sel_e;

    // Sticky error flag positions
    localparam int unsigned NERR     = 3;
    localparam int unsigned ERR_OVF  = 0;
    localparam int unsigned ERR_UNF  = 1;
    localparam int unsigned ERR_LOOP = 2;

endpackage

// File: rtl/jtdsp16_lifo.sv
// Return-address stack: push/pop LIFO with occupancy count and full/empty flags.
module jtdsp16_lifo #(
    parameter int unsigned W     = 12,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic [W-1:0]                 i_data,
    output logic [W-1:0]                 o_top_c,
    output logic                         o_full_c,
    output logic                         o_empty_c,
    output logic [$clog2(DEPTH+1)-1:0]   o_cnt
);

    localparam int unsigned CNTW = $clog2(DEPTH + 1);
    localparam int unsigned IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]    r_mem [DEPTH];
    logic [CNTW-1:0] r_cnt;
    logic [IW-1:0]   w_wr_idx;
    logic [IW-1:0]   w_rd_idx;

    // Write slot is the current count, top of stack sits one below it
    assign w_wr_idx  = IW'(r_cnt);
    assign w_rd_idx  = IW'(r_cnt - CNTW'(1));
    assign o_full_c  = (r_cnt == CNTW'(DEPTH));
    assign o_empty_c = (r_cnt == '0);
    assign o_top_c   = o_empty_c ? '0 : r_mem[w_rd_idx];
    assign o_cnt     = r_cnt;

    // Storage and occupancy; pushes on full and pops on empty are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_mem <= '{default: '0};
        end else if (i_push && !o_full_c) begin
            r_mem[w_wr_idx] <= i_data;
            r_cnt           <= r_cnt + CNTW'(1);
        end else if (i_pop && !o_empty_c) begin
            r_cnt <= r_cnt - CNTW'(1);
        end
    end

endmodule

// File: rtl/jtdsp16_pseq.sv
// Program sequencer: next ROM address with return stack, hardware do-loop and sticky errors.
module jtdsp16_pseq
    import jtdsp16_pseq_pkg::*;
#(
    parameter int unsigned AW     = 12,
    parameter int unsigned SDEPTH = 4,
    parameter int unsigned NIW    = 4,
    parameter int unsigned CW     = 7
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_cen,
    input  logic                          i_goto_en,
    input  logic                          i_call_en,
    input  logic                          i_ret_en,
    input  logic                          i_con_result,
    input  logic [AW-1:0]                 i_tgt,
    input  logic                          i_do_en,
    input  logic [NIW-1:0]                i_do_ni,
    input  logic [CW-1:0]                 i_do_k,
    input  logic                          i_clr_err,
    output logic [AW-1:0]                 o_pc,
    output logic [$clog2(SDEPTH+1)-1:0]   o_sp,
    output logic                          o_in_loop,
    output logic [CW-1:0]                 o_loop_cnt,
    output logic                          o_stack_ovf,
    output logic                          o_stack_unf,
    output logic                          o_loop_err
);

    logic [AW-1:0]   r_pc;
    logic [AW-1:0]   r_loop_start;
    logic [AW-1:0]   r_loop_end;
    logic [CW-1:0]   r_loop_cnt;
    logic            r_in_loop;
    logic [NERR-1:0] r_err;

    logic [AW-1:0]   w_pc_inc;
    logic [AW-1:0]   w_pc_nxt;
    logic [AW-1:0]   w_stack_top;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_do_start;
    logic            w_goto_tk;
    logic            w_call_tk;
    logic            w_ret_tk;
    logic            w_loop_hit;
    logic            w_loopback;
    logic [NERR-1:0] w_err_new;
    pc_sel_e         w_sel;

    assign w_pc_inc   = r_pc + AW'(1);
    assign w_goto_tk  = i_goto_en & i_con_result;
    assign w_call_tk  = i_call_en & i_con_result;
    assign w_ret_tk   = i_ret_en  & i_con_result;
    assign w_loop_hit = r_in_loop & (r_pc == r_loop_end);
    assign w_loopback = w_loop_hit & (r_loop_cnt > CW'(1));

    jtdsp16_lifo #(
        .W     (AW),
        .DEPTH (SDEPTH)
    ) u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (i_cen & w_push),
        .i_pop     (i_cen & w_pop),
        .i_data    (w_pc_inc),
        .o_top_c   (w_stack_top),
        .o_full_c  (w_full),
        .o_empty_c (w_empty),
        .o_cnt     (o_sp)
    );

    // Request arbitration: an active loop locks out all flow changes
    always_comb begin
        w_sel      = SEL_SEQ;
        w_push     = 1'b0;
        w_pop      = 1'b0;
        w_do_start = 1'b0;
        w_err_new  = '0;
        if (r_in_loop) begin
            if (i_do_en || w_call_tk || w_goto_tk || w_ret_tk) w_err_new[ERR_LOOP] = 1'b1;
            if (w_loopback) w_sel = SEL_LOOPBACK;
        end else if (i_do_en) begin
            if (i_do_ni == '0 || i_do_k == '0) w_err_new[ERR_LOOP] = 1'b1;
            else                               w_do_start = 1'b1;
        end else if (w_call_tk) begin
            w_sel = SEL_JMP;
            if (w_full) w_err_new[ERR_OVF] = 1'b1;
            else        w_push = 1'b1;
        end else if (w_goto_tk) begin
            w_sel = SEL_JMP;
        end else if (w_ret_tk) begin
            if (w_empty) begin
                w_err_new[ERR_UNF] = 1'b1;
            end else begin
                w_sel = SEL_RET;
                w_pop = 1'b1;
            end
        end
    end

    // Next-address mux
    always_comb begin
        w_pc_nxt = w_pc_inc;
        case (w_sel)
            SEL_JMP:      w_pc_nxt = i_tgt;
            SEL_RET:      w_pc_nxt = w_stack_top;
            SEL_LOOPBACK: w_pc_nxt = r_loop_start;
            default:      w_pc_nxt = w_pc_inc;
        endcase
    end

    // PC, loop registers and sticky flags; everything holds while cen is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc         <= '0;
            r_loop_start <= '0;
            r_loop_end   <= '0;
            r_loop_cnt   <= '0;
            r_in_loop    <= 1'b0;
            r_err        <= '0;
        end else if (i_cen) begin
            r_pc  <= w_pc_nxt;
            r_err <= (r_err & ~{NERR{i_clr_err}}) | w_err_new;
            if (w_do_start) begin
                r_loop_start <= w_pc_inc;
                r_loop_end   <= r_pc + AW'(i_do_ni);
                r_loop_cnt   <= i_do_k;
                r_in_loop    <= 1'b1;
            end else if (w_loopback) begin
                r_loop_cnt <= r_loop_cnt - CW'(1);
            end else if (w_loop_hit) begin
                r_loop_cnt <= '0;
                r_in_loop  <= 1'b0;
            end
        end
    end

    assign o_pc        = r_pc;
    assign o_in_loop   = r_in_loop;
    assign o_loop_cnt  = r_loop_cnt;
    assign o_stack_ovf = r_err[ERR_OVF];
    assign o_stack_unf = r_err[ERR_UNF];
    assign o_loop_err  = r_err[ERR_LOOP];

endmodule

// File: tb/tb_jtdsp16_pseq.sv
// Scoreboard bench for jtdsp16_pseq: directed scenarios plus random traffic against a behavioural model.
module tb_jtdsp16_pseq;

    localparam int AW     = 12;
    localparam int SDEPTH = 4;
    localparam int NIW    = 4;
    localparam int CW     = 7;
    localparam int MOD    = 1 << AW;
    localparam int SPW    = $clog2(SDEPTH + 1);

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           i_cen = 1'b0;
    logic           i_goto_en = 1'b0;
    logic           i_call_en = 1'b0;
    logic           i_ret_en = 1'b0;
    logic           i_con_result = 1'b0;
    logic [AW-1:0]  i_tgt = '0;
    logic           i_do_en = 1'b0;
    logic [NIW-1:0] i_do_ni = '0;
    logic [CW-1:0]  i_do_k = '0;
    logic           i_clr_err = 1'b0;
    logic [AW-1:0]  o_pc;
    logic [SPW-1:0] o_sp;
    logic           o_in_loop;
    logic [CW-1:0]  o_loop_cnt;
    logic           o_stack_ovf;
    logic           o_stack_unf;
    logic           o_loop_err;

    jtdsp16_pseq #(.AW(AW), .SDEPTH(SDEPTH), .NIW(NIW), .CW(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_cen        (i_cen),
        .i_goto_en    (i_goto_en),
        .i_call_en    (i_call_en),
        .i_ret_en     (i_ret_en),
        .i_con_result (i_con_result),
        .i_tgt        (i_tgt),
        .i_do_en      (i_do_en),
        .i_do_ni      (i_do_ni),
        .i_do_k       (i_do_k),
        .i_clr_err    (i_clr_err),
        .o_pc         (o_pc),
        .o_sp         (o_sp),
        .o_in_loop    (o_in_loop),
        .o_loop_cnt   (o_loop_cnt),
        .o_stack_ovf  (o_stack_ovf),
        .o_stack_unf  (o_stack_unf),
        .o_loop_err   (o_loop_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pc; int sp; int il; int cnt; int ovf; int unf; int lerr;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;

    // Reference model state
    int m_pc, m_start, m_end, m_cnt;
    bit m_il, m_ovf, m_unf, m_lerr;
    int m_stk[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_start = 0; m_end = 0; m_cnt = 0;
        m_il = 0; m_ovf = 0; m_unf = 0; m_lerr = 0;
        m_stk.delete();
    endtask

    // One enabled cycle of the sequencer, straight from the behavioural rules
    task automatic model_step(input bit cen, go, ca, re, con, input int tgt,
                              input bit de, input int ni, input int k, input bit clr);
        int inc, npc;
        bit e_l, e_o, e_u;
        bit tg, tc, tr;
        if (!cen) return;
        inc = (m_pc + 1) % MOD;
        npc = inc;
        e_l = 0; e_o = 0; e_u = 0;
        tg = go & con; tc = ca & con; tr = re & con;
        if (m_il) begin
            if (de || tg || tc || tr) e_l = 1;
            if (m_pc == m_end) begin
                if (m_cnt > 1) begin
                    npc = m_start;
                    m_cnt = m_cnt - 1;
                end else begin
                    m_il = 0;
                    m_cnt = 0;
                end
            end
        end else if (de) begin
            if (ni == 0 || k == 0) e_l = 1;
            else begin
                m_start = inc;
                m_end   = (m_pc + ni) % MOD;
                m_cnt   = k;
                m_il    = 1;
            end
        end else if (tc) begin
            if (m_stk.size() == SDEPTH) e_o = 1;
            else m_stk.push_back(inc);
            npc = tgt;
        end else if (tg) begin
            npc = tgt;
        end else if (tr) begin
            if (m_stk.size() == 0) e_u = 1;
            else npc = m_stk.pop_back();
        end
        m_pc   = npc;
        m_ovf  = (m_ovf  & ~clr) | e_o;
        m_unf  = (m_unf  & ~clr) | e_u;
        m_lerr = (m_lerr & ~clr) | e_l;
    endtask

    // Drive one cycle, queue its expected result, return #1 after the edge
    task automatic step(input bit cen, go, ca, re, con, input int tgt,
                        input bit de, input int ni, input int k, input bit clr);
        exp_t e;
        i_cen = cen; i_goto_en = go; i_call_en = ca; i_ret_en = re; i_con_result = con;
        i_tgt = AW'(tgt); i_do_en = de; i_do_ni = NIW'(ni); i_do_k = CW'(k); i_clr_err = clr;
        model_step(cen, go, ca, re, con, tgt, de, ni, k, clr);
        e.pc = m_pc; e.sp = m_stk.size(); e.il = int'(m_il); e.cnt = m_cnt;
        e.ovf = int'(m_ovf); e.unf = int'(m_unf); e.lerr = int'(m_lerr);
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic gotot(input int t, input bit con);
        step(1, 1, 0, 0, con, t, 0, 0, 0, 0);
    endtask
    task automatic callt(input int t);
        step(1, 0, 1, 0, 1, t, 0, 0, 0, 0);
    endtask
    task automatic rett();
        step(1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    endtask
    task automatic dot(input int ni, input int k);
        step(1, 0, 0, 0, 0, 0, 1, ni, k, 0);
    endtask
    task automatic clrt();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_pc"},   int'(o_pc), 0);
        chk({tag, "_sp"},   int'(o_sp), 0);
        chk({tag, "_il"},   int'(o_in_loop), 0);
        chk({tag, "_cnt"},  int'(o_loop_cnt), 0);
        chk({tag, "_ovf"},  int'(o_stack_ovf), 0);
        chk({tag, "_unf"},  int'(o_stack_unf), 0);
        chk({tag, "_lerr"}, int'(o_loop_err), 0);
    endtask

    // Monitor: every falling edge consumes the expectation for the preceding rising edge
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                chk("sb_pc",   int'(o_pc),        e.pc);
                chk("sb_sp",   int'(o_sp),        e.sp);
                chk("sb_il",   int'(o_in_loop),   e.il);
                chk("sb_cnt",  int'(o_loop_cnt),  e.cnt);
                chk("sb_ovf",  int'(o_stack_ovf), e.ovf);
                chk("sb_unf",  int'(o_stack_unf), e.unf);
                chk("sb_lerr", int'(o_loop_err),  e.lerr);
            end
        end
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset("rst");
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Sequential count and cen freeze
        idle(5);
        chk("seq5", int'(o_pc), 5);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("freeze", int'(o_pc), 5);

        // Single call / return
        gotot(12'h010, 1);
        chk("goto", int'(o_pc), 12'h010);
        callt(12'h200);
        chk("call_pc", int'(o_pc), 12'h200);
        chk("call_sp", int'(o_sp), 1);
        rett();
        chk("ret_pc", int'(o_pc), 12'h011);
        chk("ret_sp", int'(o_sp), 0);

        // Nesting past the stack depth, then unwinding past empty
        callt(12'h300); callt(12'h310); callt(12'h320); callt(12'h330); callt(12'h340);
        chk("ovf_pc", int'(o_pc), 12'h340);
        chk("ovf_sp", int'(o_sp), 4);
        chk("ovf_flag", int'(o_stack_ovf), 1);
        rett(); chk("pop1", int'(o_pc), 12'h321);
        rett(); chk("pop2", int'(o_pc), 12'h311);
        rett(); chk("pop3", int'(o_pc), 12'h301);
        rett(); chk("pop4", int'(o_pc), 12'h012);
        rett();
        chk("unf_pc", int'(o_pc), 12'h013);
        chk("unf_flag", int'(o_stack_unf), 1);
        clrt();
        chk("clr_ovf", int'(o_stack_ovf), 0);

        // Basic loop
        gotot(12'h100, 1);
        dot(3, 2);
        chk("lp0", int'(o_pc), 12'h101);
        chk("lp0_il", int'(o_in_loop), 1);
        idle(1); chk("lp1", int'(o_pc), 12'h102);
        idle(1); chk("lp2", int'(o_pc), 12'h103);
        idle(1); chk("lp3", int'(o_pc), 12'h101);
        idle(1); chk("lp4", int'(o_pc), 12'h102);
        idle(1); chk("lp5", int'(o_pc), 12'h103);
        chk("lp5_il", int'(o_in_loop), 1);
        idle(1); chk("lp6", int'(o_pc), 12'h104);
        chk("lp6_il", int'(o_in_loop), 0);

        // Illegal flow inside a loop, clear, legal untaken conditional
        dot(3, 5);
        gotot(12'h050, 1);
        chk("lgoto_pc", int'(o_pc), 12'h106);
        chk("lgoto_err", int'(o_loop_err), 1);
        clrt();
        chk("lclr", int'(o_loop_err), 0);
        gotot(12'h050, 0);
        chk("luntaken", int'(o_loop_err), 0);
        idle(20);
        dot(3, 0);
        chk("k0_err", int'(o_loop_err), 1);
        chk("k0_il", int'(o_in_loop), 0);
        clrt();
        dot(0, 2);
        chk("ni0_err", int'(o_loop_err), 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Loop body straddling the top of memory
        gotot(12'hFFE, 1);
        dot(3, 2);
        chk("wr0", int'(o_pc), 12'hFFF);
        idle(1); chk("wr1", int'(o_pc), 12'h000);
        idle(1); chk("wr2", int'(o_pc), 12'h001);
        idle(1); chk("wr3", int'(o_pc), 12'hFFF);
        idle(2); chk("wr5", int'(o_pc), 12'h001);
        idle(1); chk("wr6", int'(o_pc), 12'h002);

        // Asynchronous reset in the middle of a loop with a stacked address
        callt(12'h040);
        dot(4, 3);
        idle(2);
        @(negedge clk);
        #1;
        chk("q_drained", q.size(), 0);
        rst_n = 1'b0;
        #1;
        check_reset("arst");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        chk("post_rst", int'(o_pc), 1);
        rett();
        chk("post_rst_unf", int'(o_stack_unf), 1);

        // Random traffic, including simultaneous requests and stalls
        for (int n = 0; n < 1500; n++) begin
            bit cen, go, ca, re, con, de, clr;
            cen = ($urandom_range(0, 99) < 90);
            go  = ($urandom_range(0, 99) < 10);
            ca  = ($urandom_range(0, 99) < 10);
            re  = ($urandom_range(0, 99) < 12);
            de  = ($urandom_range(0, 99) < 6);
            con = ($urandom_range(0, 99) < 70);
            clr = ($urandom_range(0, 99) < 5);
            step(cen, go, ca, re, con, int'($urandom_range(0, MOD - 1)), de,
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), clr);
        end

        for (int w = 0; w < 5 && q.size() > 0; w++) @(negedge clk);
        #1;
        chk("final_drain", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
